// File: rtl/mem_bus_arbiter_pkg.sv
// Shared bus definitions for the memory bus arbiter: command encoding, tag
// geometry and the owner-table entry layout.
package mem_bus_arbiter_pkg;

    localparam int XLEN         = 32;
    localparam int NUM_MEM_TAGS = 15;
    localparam int TAG_W        = 4;
    // The owner field is sized for the largest supported requester count.
    localparam int MAX_REQ      = 4;
    localparam int OWNER_W      = $clog2(MAX_REQ);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

    typedef struct packed {
        logic               valid;
        logic [OWNER_W-1:0] owner;
    } owner_entry_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the arbiter. The master modport is the
// arbiter itself; slave is the cache controllers plus the memory model.
interface mem_bus_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int OCNT_W  = 4
) ();
    import mem_bus_arbiter_pkg::*;

    logic [NUM_REQ-1:0][XLEN-1:0]   req_addr;
    logic [NUM_REQ-1:0][63:0]       req_data;
    logic [NUM_REQ-1:0][1:0]        req_command;
    logic [NUM_REQ-1:0][TAG_W-1:0]  req_response;
    logic [NUM_REQ-1:0][63:0]       req_rdata;
    logic [NUM_REQ-1:0][TAG_W-1:0]  req_rtag;
    logic [NUM_REQ-1:0][OCNT_W-1:0] req_outstanding;

    logic [XLEN-1:0]  proc2mem_addr;
    logic [63:0]      proc2mem_data;
    logic [1:0]       proc2mem_command;
    logic [TAG_W-1:0] mem2proc_response;
    logic [63:0]      mem2proc_data;
    logic [TAG_W-1:0] mem2proc_tag;

    logic             err_stray_tag;

    modport master (
        input  req_addr, req_data, req_command,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output req_response, req_rdata, req_rtag, req_outstanding,
        output proc2mem_addr, proc2mem_data, proc2mem_command,
        output err_stray_tag
    );

    modport slave (
        output req_addr, req_data, req_command,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  req_response, req_rdata, req_rtag, req_outstanding,
        input  proc2mem_addr, proc2mem_data, proc2mem_command,
        input  err_stray_tag
    );

endinterface

// File: rtl/mem_bus_arbiter_arb_grant.sv
// Combinational grant selection. With MEM_ARB_RR_EN defined the search starts
// at a registered round-robin pointer; otherwise the lowest index wins.
module arb_grant
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
`ifdef MEM_ARB_RR_EN
    input  logic               clk,
    input  logic               rst,
    input  logic               accepted,
`endif
    input  logic [NUM_REQ-1:0] req_valid,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
);

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0] ptr_q;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_valid && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // A refused requester keeps the pointer, so it stays first in line.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (grant_valid && accepted) begin
            ptr_q <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : IDX_W'(int'(grant_idx) + 1);
        end
    end
`else
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the tagged memory bus between NUM_REQ requesters and routes returned
// load data through a per-tag owner table. Round-robin grant: MEM_ARB_RR_EN.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_TAGS = NUM_MEM_TAGS,
    parameter int OCNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_arbiter_if.master bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [OCNT_W-1:0] CNT_MAX = '1;

    logic [NUM_REQ-1:0]         req_active;
    logic                       grant_valid;
    logic [IDX_W-1:0]           grant_idx;
    logic                       mem_accept;
    logic                       load_alloc;
    logic                       tag_present;
    logic                       ret_hit;
    owner_entry_t               ret_entry;
    owner_entry_t               owner_tbl [1:NUM_TAGS];
    logic [NUM_REQ-1:0]         cnt_inc;
    logic [NUM_REQ-1:0]         cnt_dec;
    logic [NUM_REQ-1:0][OCNT_W-1:0] ocnt_q;
    logic                       err_q;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_active[i] = (bus.req_command[i] != BUS_NONE);
        end
    end

    arb_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_grant (
`ifdef MEM_ARB_RR_EN
        .clk         (clk),
        .rst         (rst),
        .accepted    (mem_accept),
`endif
        .req_valid   (req_active),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign mem_accept  = grant_valid && (bus.mem2proc_response != '0);
    assign load_alloc  = mem_accept && (bus.req_command[grant_idx] == BUS_LOAD);
    assign tag_present = (bus.mem2proc_tag != '0);

    // Request path is a pure mux; non-granted requesters see a zero response.
    always_comb begin
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.proc2mem_command = BUS_NONE;
        bus.req_response     = '0;
        if (grant_valid) begin
            bus.proc2mem_addr               = bus.req_addr[grant_idx];
            bus.proc2mem_data               = bus.req_data[grant_idx];
            bus.proc2mem_command            = bus.req_command[grant_idx];
            bus.req_response[grant_idx]     = bus.mem2proc_response;
        end
    end

    always_comb begin
        ret_entry = '0;
        for (int t = 1; t <= NUM_TAGS; t++) begin
            if (bus.mem2proc_tag == TAG_W'(t)) begin
                ret_entry = owner_tbl[t];
            end
        end
    end

    assign ret_hit = tag_present && ret_entry.valid;

    always_comb begin
        bus.req_rtag  = '0;
        bus.req_rdata = '0;
        cnt_inc       = '0;
        cnt_dec       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ret_hit && ret_entry.owner == OWNER_W'(i)) begin
                bus.req_rtag[i]  = bus.mem2proc_tag;
                bus.req_rdata[i] = bus.mem2proc_data;
                cnt_dec[i]       = 1'b1;
            end
            cnt_inc[i] = load_alloc && (grant_idx == IDX_W'(i));
        end
    end

    // Allocation takes precedence over a same-cycle return of the same tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 1; t <= NUM_TAGS; t++) begin
                owner_tbl[t] <= '0;
            end
        end else begin
            for (int t = 1; t <= NUM_TAGS; t++) begin
                if (load_alloc && bus.mem2proc_response == TAG_W'(t)) begin
                    owner_tbl[t] <= '{valid: 1'b1, owner: OWNER_W'(grant_idx)};
                end else if (ret_hit && bus.mem2proc_tag == TAG_W'(t)) begin
                    owner_tbl[t].valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ocnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (cnt_inc[i] && !cnt_dec[i] && ocnt_q[i] != CNT_MAX) begin
                    ocnt_q[i] <= ocnt_q[i] + 1'b1;
                end else if (cnt_dec[i] && !cnt_inc[i] && ocnt_q[i] != '0) begin
                    ocnt_q[i] <= ocnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (tag_present && !ret_hit) begin
            err_q <= 1'b1;
        end
    end

    assign bus.req_outstanding = ocnt_q;
    assign bus.err_stray_tag   = err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter; covers both the default fixed-priority
// build and the MEM_ARB_RR_EN build.
module tb_mem_bus_arbiter;
    import mem_bus_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int OCW  = 4;

    localparam logic [1:0] EV_BUS  = 2'd0;
    localparam logic [1:0] EV_RESP = 2'd1;
    localparam logic [1:0] EV_RET  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [1:0]  idx;
        logic [3:0]  tag;
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ev_t  exp_q [$];
    ev_t  obs [$];
    int   checks = 0;
    int   errors = 0;

    mem_bus_arbiter_if #(.NUM_REQ(NREQ), .OCNT_W(OCW)) bus ();

    mem_bus_arbiter #(
        .NUM_REQ  (NREQ),
        .NUM_TAGS (NUM_MEM_TAGS),
        .OCNT_W   (OCW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] reqData(input int idx, input logic [31:0] addr);
        return {16'hDA7A, 16'(idx), addr};
    endfunction

    function automatic ev_t mkEv(input logic [1:0] kind, input int idx, input logic [3:0] tag,
                                 input logic [1:0] cmd, input logic [31:0] addr, input logic [63:0] data);
        ev_t e;
        e.kind = kind;
        e.idx  = 2'(idx);
        e.tag  = tag;
        e.cmd  = cmd;
        e.addr = addr;
        e.data = data;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] c0, input logic [31:0] a0,
                                 input logic [1:0] c1, input logic [31:0] a1,
                                 input logic [3:0] resp, input logic [3:0] tag, input logic [63:0] rd);
        @(posedge clk);
        #1;
        bus.req_command[0]    = c0;
        bus.req_addr[0]       = a0;
        bus.req_data[0]       = reqData(0, a0);
        bus.req_command[1]    = c1;
        bus.req_addr[1]       = a1;
        bus.req_data[1]       = reqData(1, a1);
        bus.mem2proc_response = resp;
        bus.mem2proc_tag      = tag;
        bus.mem2proc_data     = rd;
    endtask

    task automatic idle();
        applyStimulus(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd0, 64'h0);
    endtask

    task automatic expBus(input int g, input logic [1:0] cmd, input logic [31:0] addr);
        exp_q.push_back(mkEv(EV_BUS, 0, 4'd0, cmd, addr, reqData(g, addr)));
    endtask

    task automatic expResp(input int g, input logic [3:0] tag);
        exp_q.push_back(mkEv(EV_RESP, g, tag, 2'd0, 32'h0, 64'h0));
    endtask

    task automatic expRet(input int g, input logic [3:0] tag, input logic [63:0] data);
        exp_q.push_back(mkEv(EV_RET, g, tag, 2'd0, 32'h0, data));
    endtask

    // Monitor: every visible bus command, accept or return pops one expectation.
    always @(negedge clk) begin
        obs.delete();
        if (bus.proc2mem_command != BUS_NONE) begin
            obs.push_back(mkEv(EV_BUS, 0, 4'd0, bus.proc2mem_command, bus.proc2mem_addr, bus.proc2mem_data));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_response[i] != 4'd0) obs.push_back(mkEv(EV_RESP, i, bus.req_response[i], 2'd0, 32'h0, 64'h0));
            if (bus.req_rtag[i] != 4'd0) obs.push_back(mkEv(EV_RET, i, bus.req_rtag[i], 2'd0, 32'h0, bus.req_rdata[i]));
        end
        foreach (obs[k]) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got %h, expected nothing", obs[k]);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (obs[k] !== e) begin
                    errors++;
                    $display("[TB] FAIL sb_event: got %h, expected %h", obs[k], e);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_missing: got nothing, expected %h (%0d pending)", exp_q[0], exp_q.size());
            exp_q.delete();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.req_command       = '0;
        bus.req_addr          = '0;
        bus.req_data          = '0;
        bus.mem2proc_response = '0;
        bus.mem2proc_tag      = '0;
        bus.mem2proc_data     = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle();
        checkOutput("rst_ocnt0", 64'(bus.req_outstanding[0]), 64'd0);
        checkOutput("rst_ocnt1", 64'(bus.req_outstanding[1]), 64'd0);
        checkOutput("rst_err", 64'(bus.err_stray_tag), 64'd0);
        checkOutput("rst_resp", 64'(bus.req_response), 64'd0);
        checkOutput("rst_rtag", 64'(bus.req_rtag), 64'd0);

        // Both load together: req0 wins, req1 retries and wins next cycle.
        applyStimulus(BUS_LOAD, 32'h100, BUS_LOAD, 32'h200, 4'd1, 4'd0, 64'h0);
        expBus(0, BUS_LOAD, 32'h100);
        expResp(0, 4'd1);
        applyStimulus(BUS_NONE, 32'h0, BUS_LOAD, 32'h200, 4'd2, 4'd0, 64'h0);
        expBus(1, BUS_LOAD, 32'h200);
        expResp(1, 4'd2);
        applyStimulus(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd1, 64'hAAAA_0001);
        expRet(0, 4'd1, 64'hAAAA_0001);
        checkOutput("t1_ocnt0", 64'(bus.req_outstanding[0]), 64'd1);
        checkOutput("t1_ocnt1", 64'(bus.req_outstanding[1]), 64'd1);
        applyStimulus(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd2, 64'hBBBB_0002);
        expRet(1, 4'd2, 64'hBBBB_0002);
        checkOutput("t1_ocnt0_ret", 64'(bus.req_outstanding[0]), 64'd0);
        idle();
        checkOutput("t1_ocnt1_ret", 64'(bus.req_outstanding[1]), 64'd0);

        // Store allocates nothing, so a later tag 3 is a stray.
        applyStimulus(BUS_NONE, 32'h0, BUS_STORE, 32'h40, 4'd3, 4'd0, 64'h0);
        expBus(1, BUS_STORE, 32'h40);
        expResp(1, 4'd3);
        idle();
        checkOutput("t2_ocnt1", 64'(bus.req_outstanding[1]), 64'd0);
        checkOutput("t2_err_pre", 64'(bus.err_stray_tag), 64'd0);
        applyStimulus(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd3, 64'hDEAD);
        idle();
        checkOutput("t2_err", 64'(bus.err_stray_tag), 64'd1);

        // Continuous requests: alternate under round-robin, req0 under fixed.
        for (int k = 0; k < 4; k++) begin
            int g;
`ifdef MEM_ARB_RR_EN
            g = k % 2;
`else
            g = 0;
`endif
            applyStimulus(BUS_STORE, 32'h300, BUS_STORE, 32'h400, 4'd4, 4'd0, 64'h0);
            expBus(g, BUS_STORE, (g == 0) ? 32'h300 : 32'h400);
            expResp(g, 4'd4);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(BUS_STORE, 32'h300, BUS_STORE, 32'h400, 4'd0, 4'd0, 64'h0);
            expBus(0, BUS_STORE, 32'h300);
        end
        applyStimulus(BUS_STORE, 32'h300, BUS_STORE, 32'h400, 4'd4, 4'd0, 64'h0);
        expBus(0, BUS_STORE, 32'h300);
        expResp(0, 4'd4);
        applyStimulus(BUS_NONE, 32'h0, BUS_STORE, 32'h400, 4'd4, 4'd0, 64'h0);
        expBus(1, BUS_STORE, 32'h400);
        expResp(1, 4'd4);

        // Tag 5 returns to req0 while req1 is handed tag 5.
        applyStimulus(BUS_LOAD, 32'h500, BUS_NONE, 32'h0, 4'd5, 4'd0, 64'h0);
        expBus(0, BUS_LOAD, 32'h500);
        expResp(0, 4'd5);
        applyStimulus(BUS_NONE, 32'h0, BUS_LOAD, 32'h600, 4'd5, 4'd5, 64'h5555);
        expBus(1, BUS_LOAD, 32'h600);
        expRet(0, 4'd5, 64'h5555);
        expResp(1, 4'd5);
        checkOutput("t4_ocnt0_pre", 64'(bus.req_outstanding[0]), 64'd1);
        idle();
        checkOutput("t4_ocnt0", 64'(bus.req_outstanding[0]), 64'd0);
        checkOutput("t4_ocnt1", 64'(bus.req_outstanding[1]), 64'd1);
        applyStimulus(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd5, 64'h6666);
        expRet(1, 4'd5, 64'h6666);
        idle();
        checkOutput("t4_ocnt1_ret", 64'(bus.req_outstanding[1]), 64'd0);
        checkOutput("t4_err_sticky", 64'(bus.err_stray_tag), 64'd1);

        // Reset with two loads in flight; their late returns become strays.
        applyStimulus(BUS_LOAD, 32'h700, BUS_NONE, 32'h0, 4'd6, 4'd0, 64'h0);
        expBus(0, BUS_LOAD, 32'h700);
        expResp(0, 4'd6);
        applyStimulus(BUS_LOAD, 32'h708, BUS_NONE, 32'h0, 4'd7, 4'd0, 64'h0);
        expBus(0, BUS_LOAD, 32'h708);
        expResp(0, 4'd7);
        idle();
        checkOutput("t5_ocnt0_pre", 64'(bus.req_outstanding[0]), 64'd2);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("t5_ocnt0_rst", 64'(bus.req_outstanding[0]), 64'd0);
        checkOutput("t5_err_rst", 64'(bus.err_stray_tag), 64'd0);
        applyStimulus(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd6, 64'h77);
        applyStimulus(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'd7, 64'h78);
        idle();
        checkOutput("t5_err", 64'(bus.err_stray_tag), 64'd1);
        checkOutput("t5_ocnt0", 64'(bus.req_outstanding[0]), 64'd0);

        // Fifteen loads fill the counter, a sixteenth saturates, returns drain it.
        for (int t = 1; t <= 15; t++) begin
            applyStimulus(BUS_LOAD, 32'h1000 + 32'(t * 8), BUS_NONE, 32'h0, 4'(t), 4'd0, 64'h0);
            expBus(0, BUS_LOAD, 32'h1000 + 32'(t * 8));
            expResp(0, 4'(t));
        end
        idle();
        checkOutput("t6_ocnt0_full", 64'(bus.req_outstanding[0]), 64'd15);
        applyStimulus(BUS_LOAD, 32'h2000, BUS_NONE, 32'h0, 4'd1, 4'd0, 64'h0);
        expBus(0, BUS_LOAD, 32'h2000);
        expResp(0, 4'd1);
        idle();
        checkOutput("t6_ocnt0_sat", 64'(bus.req_outstanding[0]), 64'd15);
        for (int t = 1; t <= 15; t++) begin
            applyStimulus(BUS_NONE, 32'h0, BUS_NONE, 32'h0, 4'd0, 4'(t), 64'hC0DE_0000 + 64'(t));
            expRet(0, 4'(t), 64'hC0DE_0000 + 64'(t));
        end
        idle();
        checkOutput("t6_ocnt0_empty", 64'(bus.req_outstanding[0]), 64'd0);
        checkOutput("t6_ocnt1", 64'(bus.req_outstanding[1]), 64'd0);

        idle();
        idle();
        checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
